encoder_scan: RTL and testbench
===============================

# encoder_scan

Parametrised sequential priority encoder, the successor to the fixed 8-to-3 combinational encoder. It captures an N-bit request vector on a load strobe and emits the index of every set bit, one per accepted transfer, highest priority first, over a valid/ready handshake. It also reports the population count of the captured vector and flags an all-zero load. It sits between request-collecting logic (keypad/switch scanners, interrupt lines) and a single-index consumer such as a display decoder or a dispatcher.

## Interface
- N, 8, number of request inputs (N ≥ 2)
- W, $clog2(N), index width
- MSB_FIRST, 1, 1: highest set bit served first; 0: lowest set bit served first

- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-high
- iData  in  N  request vector, sampled only on an accepted load
- iLoad  in  1  load strobe
- iReady  in  1  consumer accepts oData this cycle
- oData  out  W  index of the current highest-priority pending bit
- oValid  out  1  oData is valid
- oBusy  out  1  scan in progress; loads are ignored
- oCount  out  $clog2(N+1)  popcount of the last captured vector
- oNone  out  1  one-cycle pulse: the last load was all-zero
- oDone  out  1  one-cycle pulse: the final index of a scan was accepted

## Operation
- Clock and reset: one clock, iClk. Reset iRst is asynchronous and active-high.
- State: a 2-state FSM, IDLE and SCAN, plus an N-bit pending register.
- Reset forces IDLE, clears pending to 0, and sets oData=0, oValid=0, oBusy=0, oCount=0, oNone=0, oDone=0.
- IDLE, iLoad=1, iData≠0:
  - pending ← iData
  - oCount ← popcount(iData)
  - next state SCAN
- IDLE, iLoad=1, iData=0:
  - oCount ← 0
  - oNone pulses for 1 cycle
  - state stays IDLE
- IDLE, iLoad=0: nothing changes. oCount holds its last value.
- SCAN:
  - oValid=1, oBusy=1.
  - oData is the index of the top pending bit. With MSB_FIRST=1 this is the highest set index; with MSB_FIRST=0 it is the lowest.
- SCAN handshake:
  - A transfer occurs on a rising edge with oValid=1 and iReady=1.
  - On a transfer, the served bit is cleared from pending.
  - If that bit was the last one set: oDone pulses in the following cycle, state returns to IDLE, and oValid and oBusy drop.
- SCAN with iReady=0: oData and oValid hold stable. oData must not change while oValid=1 and no transfer has occurred.
- iLoad during SCAN is ignored; pending and oCount are unaffected. The load is not queued.
- Indices go out strictly in priority order, exactly once per set bit, so each scan produces oCount transfers.
- oData and oValid depend only on registered state. There is no combinational path from iData, iLoad or iReady to any output.
- Reset asserted mid-scan aborts immediately to the reset values. No oDone is generated.

## Timing
- Load-to-first-index latency: iLoad sampled at edge k gives oValid=1 with a valid oData in the cycle after edge k.
- Throughput: one index per cycle while iReady is held high. A vector with M set bits completes in M cycles after the first valid cycle.
- oDone and oNone are each high for exactly one cycle, in the cycle after the triggering edge.
- Last transfer at edge t gives oValid=0 and oBusy=0 after t. A new iLoad is accepted at edge t+1 at the earliest; there is no back-to-back load on the same edge as the last transfer.
- oCount updates in the cycle after an accepted load and holds until the next accepted load or reset.
- oData while oValid=0 is don't-care. The implementation drives 0.

## Test plan
- Reset: hold iRst mid-stream -> all outputs 0 asynchronously, before the next clock edge. After release, state is IDLE.
- N=8, MSB_FIRST=1, one-hot walk: load 8'b10000000 through 8'b00000001 with iReady=1 -> oData 7,6,5,4,3,2,1,0 respectively; oCount=1 and one oDone pulse for each load.
- Multi-bit scan: load 8'b10100101 with iReady=1 -> oData 7,5,2,0 on four consecutive cycles, oCount=4, oDone once after index 0. With MSB_FIRST=0 the same load gives 0,2,5,7.
- Backpressure: load 8'b01000010, hold iReady=0 for 3 cycles -> oData=6 stable with oValid=1. Then raise iReady -> 6 then 1, then oDone.
- Zero and ignored loads: load 8'h00 -> one oNone pulse, oCount=0, oValid stays 0. During a scan, pulse iLoad with 8'hFF -> ignored; the scan output sequence is unchanged.
- Parametrisation and abort: N=16, load 16'h8001 -> oData 15 then 0, oCount=2. Assert iRst after the first transfer -> no oDone, outputs 0.

Source files
------------

// File: rtl/encoder_scan.sv
`default_nettype none
// ============================================================================
// Module   : encoder_scan
// Function : Sequential priority encoder; emits every set index of a captured
//            request vector, one per valid/ready transfer, plus its popcount.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_scan #(
   parameter int N         = 8,
   parameter int W         = $clog2(N),
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic [N-1:0]           iData,
   input  logic                   iLoad,
   input  logic                   iReady,
   output logic [W-1:0]           oData,
   output logic                   oValid,
   output logic                   oBusy,
   output logic [$clog2(N+1)-1:0] oCount,
   output logic                   oNone,
   output logic                   oDone
);

   localparam int CW = $clog2(N+1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t          r_state,   w_stateNext;
   logic [N-1:0]    r_pending, w_pendingNext;
   logic [CW-1:0]   r_count,   w_countNext;
   logic            r_none,    w_noneNext;
   logic            r_done,    w_doneNext;
   logic [W-1:0]    w_topIdx;
   logic [N-1:0]    w_pendingClr;

   function automatic logic [CW-1:0] popCount(input logic [N-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   // Later loop iterations overwrite earlier ones, so the scan direction
   // decides which set bit wins.
   generate
      if (MSB_FIRST) begin : g_msbFirst
         always_comb begin
            w_topIdx = '0;
            for (int i = 0; i < N; i++) if (r_pending[i]) w_topIdx = W'(i);
         end
      end else begin : g_lsbFirst
         always_comb begin
            w_topIdx = '0;
            for (int i = N-1; i >= 0; i--) if (r_pending[i]) w_topIdx = W'(i);
         end
      end
   endgenerate

   assign w_pendingClr = r_pending & ~(N'(1) << w_topIdx);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_count   <= '0;
         r_none    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_pending <= w_pendingNext;
         r_count   <= w_countNext;
         r_none    <= w_noneNext;
         r_done    <= w_doneNext;
      end
   end

   always_comb begin
      w_stateNext   = r_state;
      w_pendingNext = r_pending;
      w_countNext   = r_count;
      w_noneNext    = 1'b0;
      w_doneNext    = 1'b0;
      case (r_state)
         IDLE: begin
            if (iLoad) begin
               if (|iData) begin
                  w_pendingNext = iData;
                  w_countNext   = popCount(iData);
                  w_stateNext   = SCAN;
               end else begin
                  w_countNext = '0;
                  w_noneNext  = 1'b1;
               end
            end
         end
         SCAN: begin
            // Loads are deliberately not examined here: they are dropped.
            if (iReady) begin
               w_pendingNext = w_pendingClr;
               if (w_pendingClr == '0) begin
                  w_stateNext = IDLE;
                  w_doneNext  = 1'b1;
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   assign oValid = (r_state == SCAN);
   assign oBusy  = (r_state == SCAN);
   assign oData  = (r_state == SCAN) ? w_topIdx : '0;
   assign oCount = r_count;
   assign oNone  = r_none;
   assign oDone  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_encoder_scan.sv
`default_nettype none
// Testbench for encoder_scan: MSB-first and LSB-first N=8 instances share
// stimulus; an N=16 instance covers wider vectors and mid-scan abort.
module tb_encoder_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data8;
   logic       load8, ready8;
   logic [2:0] dat8M, dat8L;
   logic [3:0] cnt8M, cnt8L;
   logic       valid8M, busy8M, none8M, done8M;
   logic       valid8L, busy8L, none8L, done8L;
   logic [15:0] data16;
   logic        load16, ready16;
   logic [3:0]  dat16;
   logic [4:0]  cnt16;
   logic        valid16, busy16, none16, done16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   encoder_scan #(.N(8), .MSB_FIRST(1'b1)) dutM (
      .iClk(clk), .iRst(rst), .iData(data8), .iLoad(load8), .iReady(ready8),
      .oData(dat8M), .oValid(valid8M), .oBusy(busy8M), .oCount(cnt8M),
      .oNone(none8M), .oDone(done8M));

   encoder_scan #(.N(8), .MSB_FIRST(1'b0)) dutL (
      .iClk(clk), .iRst(rst), .iData(data8), .iLoad(load8), .iReady(ready8),
      .oData(dat8L), .oValid(valid8L), .oBusy(busy8L), .oCount(cnt8L),
      .oNone(none8L), .oDone(done8L));

   encoder_scan #(.N(16), .MSB_FIRST(1'b1)) dut16 (
      .iClk(clk), .iRst(rst), .iData(data16), .iLoad(load16), .iReady(ready16),
      .oData(dat16), .oValid(valid16), .oBusy(busy16), .oCount(cnt16),
      .oNone(none16), .oDone(done16));

   // Caller must be in the negedge phase; returns in the negedge phase right
   // after the final transfer so a following call exercises back-to-back load.
   task automatic scan8(input logic [7:0] v, input bit rnd, input int hold, input bit inject);
      int qm[$];
      int ql[$];
      int guard;
      bit rdy;
      logic [3:0] cnt;
      for (int i = 7; i >= 0; i--) if (v[i]) qm.push_back(i);
      for (int i = 0; i < 8; i++)  if (v[i]) ql.push_back(i);
      cnt = 4'($countones(v));
      data8 = v; load8 = 1'b1; ready8 = 1'b0;
      @(negedge clk);
      load8 = 1'b0; data8 = 8'($urandom);
      checks++;
      if (cnt8M !== cnt || cnt8L !== cnt) begin
         errors++;
         $display("FAIL scan_count v=%h got %0d/%0d exp %0d", v, cnt8M, cnt8L, cnt);
      end
      guard = 0;
      while (qm.size() > 0) begin
         checks++;
         if ({valid8M, busy8M, done8M, valid8L, busy8L, done8L} !== 6'b110110) begin
            errors++;
            $display("FAIL scan_flags v=%h got %b exp 110110", v,
                     {valid8M, busy8M, done8M, valid8L, busy8L, done8L});
         end
         checks++;
         if (dat8M !== 3'(qm[0]) || dat8L !== 3'(ql[0])) begin
            errors++;
            $display("FAIL scan_index v=%h got %0d/%0d exp %0d/%0d", v, dat8M, dat8L, qm[0], ql[0]);
         end
         rdy = (guard < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         ready8 = rdy;
         if (inject) begin load8 = 1'b1; data8 = 8'hFF; end
         @(negedge clk);
         guard++;
         if (rdy) begin qm.delete(0); ql.delete(0); end
         if (guard > 200) begin
            errors++;
            $display("FAIL scan_timeout v=%h got pending %0d exp 0", v, qm.size());
            break;
         end
      end
      ready8 = 1'b0; load8 = 1'b0;
      checks++;
      if ({valid8M, busy8M, done8M, valid8L, busy8L, done8L} !== 6'b001001) begin
         errors++;
         $display("FAIL scan_end v=%h got %b exp 001001", v,
                  {valid8M, busy8M, done8M, valid8L, busy8L, done8L});
      end
      checks++;
      if (cnt8M !== cnt || cnt8L !== cnt) begin
         errors++;
         $display("FAIL count_hold v=%h got %0d/%0d exp %0d", v, cnt8M, cnt8L, cnt);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      data8 = '0; load8 = 1'b0; ready8 = 1'b0;
      data16 = '0; load16 = 1'b0; ready16 = 1'b0;
      @(negedge clk);
      checks++;
      if ({dat8M, valid8M, busy8M, cnt8M, none8M, done8M,
           dat8L, valid8L, busy8L, cnt8L, none8L, done8L,
           dat16, valid16, busy16, cnt16, none16, done16} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got nonzero exp all zero");
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid8M, busy8M, valid8L, busy8L, valid16, busy16} !== 6'b0) begin
         errors++;
         $display("FAIL reset_idle got %b exp 000000", {valid8M, busy8M, valid8L, busy8L, valid16, busy16});
      end
   endtask

   task automatic test_one_hot;
      logic [7:0] v;
      for (int i = 7; i >= 0; i--) begin
         v = 8'h01 << i;
         scan8(v, 1'b0, 0, 1'b0);
         @(negedge clk);
      end
   endtask

   task automatic test_multi;
      scan8(8'hA5, 1'b0, 0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      scan8(8'h42, 1'b0, 3, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_zero_load;
      data8 = 8'h00; load8 = 1'b1;
      @(negedge clk);
      load8 = 1'b0;
      checks++;
      if ({none8M, none8L, valid8M, valid8L, cnt8M, cnt8L} !== {4'b1100, 8'h00}) begin
         errors++;
         $display("FAIL zero_load got none=%b%b valid=%b%b cnt=%0d/%0d exp none=11 valid=00 cnt=0",
                  none8M, none8L, valid8M, valid8L, cnt8M, cnt8L);
      end
      @(negedge clk);
      checks++;
      if ({none8M, none8L, done8M, done8L, valid8M, valid8L} !== 6'b0) begin
         errors++;
         $display("FAIL zero_pulse_len got %b exp 000000", {none8M, none8L, done8M, done8L, valid8M, valid8L});
      end
   endtask

   task automatic test_ignored_load;
      scan8(8'h3C, 1'b0, 1, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      scan8(8'h81, 1'b0, 0, 1'b0);
      scan8(8'h18, 1'b0, 0, 1'b0);
      scan8(8'hE7, 1'b1, 0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [7:0] v;
      for (int n = 0; n < 30; n++) begin
         v = 8'($urandom);
         if ($urandom_range(0, 5) == 0) v = 8'h00;
         if (v == 8'h00) test_zero_load();
         else begin
            scan8(v, 1'b1, 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_abort8;
      data8 = 8'hA5; load8 = 1'b1; ready8 = 1'b1;
      @(negedge clk);
      load8 = 1'b0;
      @(negedge clk);
      checks++;
      if (dat8M !== 3'd5 || dat8L !== 3'd2 || valid8M !== 1'b1) begin
         errors++;
         $display("FAIL abort8_pre got %0d/%0d valid=%b exp 5/2 valid=1", dat8M, dat8L, valid8M);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({dat8M, valid8M, busy8M, cnt8M, none8M, done8M,
           dat8L, valid8L, busy8L, cnt8L, none8L, done8L} !== '0) begin
         errors++;
         $display("FAIL abort8_async got nonzero exp all zero");
      end
      @(negedge clk);
      rst = 1'b0; ready8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({valid8M, done8M, valid8L, done8L} !== 4'b0) begin
            errors++;
            $display("FAIL abort8_post got %b exp 0000", {valid8M, done8M, valid8L, done8L});
         end
      end
   endtask

   task automatic test_n16;
      data16 = 16'h8001; load16 = 1'b1; ready16 = 1'b1;
      @(negedge clk);
      load16 = 1'b0;
      checks++;
      if ({valid16, dat16, cnt16} !== {1'b1, 4'd15, 5'd2}) begin
         errors++;
         $display("FAIL n16_first got valid=%b idx=%0d cnt=%0d exp valid=1 idx=15 cnt=2", valid16, dat16, cnt16);
      end
      @(negedge clk);
      checks++;
      if ({valid16, dat16} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL n16_second got valid=%b idx=%0d exp valid=1 idx=0", valid16, dat16);
      end
      @(negedge clk);
      ready16 = 1'b0;
      checks++;
      if ({valid16, busy16, done16} !== 3'b001) begin
         errors++;
         $display("FAIL n16_done got %b exp 001", {valid16, busy16, done16});
      end
      @(negedge clk);
      data16 = 16'h8001; load16 = 1'b1; ready16 = 1'b1;
      @(negedge clk);
      load16 = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid16, dat16} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL n16_abort_pre got valid=%b idx=%0d exp valid=1 idx=0", valid16, dat16);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({dat16, valid16, busy16, cnt16, none16, done16} !== '0) begin
         errors++;
         $display("FAIL n16_abort_async got nonzero exp all zero");
      end
      @(negedge clk);
      rst = 1'b0; ready16 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({valid16, done16} !== 2'b0) begin
            errors++;
            $display("FAIL n16_abort_post got %b exp 00", {valid16, done16});
         end
      end
   endtask

   initial begin
      test_reset();
      test_one_hot();
      test_multi();
      test_backpressure();
      test_zero_load();
      test_ignored_load();
      test_back_to_back();
      test_random();
      test_abort8();
      test_n16();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
